// File: rtl/sparse_pe_pkg.sv
// sparse_pe_pkg: shared defaults and beat/response types for the sparse PE activation RAM
package sparse_pe_pkg;
    localparam int ARAM_NUM_CH   = 8;
    localparam int ARAM_DEPTH    = 64;
    localparam int ARAM_DW       = 16;
    localparam int ARAM_IW       = 4;
    localparam int ARAM_WR_LANES = 4;
    localparam int ARAM_RD_LANES = 4;

    typedef struct packed {
        logic [ARAM_WR_LANES-1:0]         valid;
        logic [$clog2(ARAM_NUM_CH)-1:0]   ch;
        logic [ARAM_WR_LANES*ARAM_DW-1:0] data;
        logic [ARAM_WR_LANES*ARAM_IW-1:0] idx;
    } aram_wr_beat_t;

    typedef struct packed {
        logic                             valid;
        logic [ARAM_RD_LANES-1:0]         lane_valid;
        logic [ARAM_RD_LANES*ARAM_DW-1:0] data;
        logic [ARAM_RD_LANES*ARAM_IW-1:0] idx;
        logic [$clog2(ARAM_DEPTH+1)-1:0]  cnt;
    } aram_rd_resp_t;
endpackage

// File: rtl/sparse_pingpong_aram_bank.sv
// aram_bank: one bank of compressed channel storage, compacting write, count clear, masked read (drop flag with IOARAM_OVF_EN)
module aram_bank
    import sparse_pe_pkg::*;
#(
    parameter int NUM_CH   = ARAM_NUM_CH,
    parameter int DEPTH    = ARAM_DEPTH,
    parameter int DW       = ARAM_DW,
    parameter int IW       = ARAM_IW,
    parameter int WR_LANES = ARAM_WR_LANES,
    parameter int RD_LANES = ARAM_RD_LANES
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clr,
    input  logic                         zap,
    input  logic [WR_LANES-1:0]          wr_valid,
    input  logic [$clog2(NUM_CH)-1:0]    wr_ch,
    input  logic [WR_LANES*DW-1:0]       wr_data,
    input  logic [WR_LANES*IW-1:0]       wr_idx,
    input  logic [$clog2(NUM_CH)-1:0]    rd_ch,
    input  logic [$clog2(DEPTH)-1:0]     rd_base,
    output logic [RD_LANES-1:0]          rd_lane_valid,
    output logic [RD_LANES*DW-1:0]       rd_data,
    output logic [RD_LANES*IW-1:0]       rd_idx,
    output logic [$clog2(DEPTH+1)-1:0]   rd_cnt
`ifdef IOARAM_OVF_EN
    ,
    output logic                         drop
`endif
);
    localparam int AW = $clog2(DEPTH);
    localparam int NW = $clog2(DEPTH+1);

    logic [DW-1:0] mem_d [NUM_CH][DEPTH];
    logic [IW-1:0] mem_i [NUM_CH][DEPTH];
    logic [NW-1:0] cnt [NUM_CH];
    logic [WR_LANES-1:0] we;
    logic [AW-1:0] wa [WR_LANES];
    logic [NW-1:0] cnt_nx;
    int p;
    int q;

    // compact valid lanes onto consecutive slots from the (possibly cleared) count
    always_comb begin
        p = clr ? 0 : int'(cnt[wr_ch]);
        we = '0;
`ifdef IOARAM_OVF_EN
        drop = 1'b0;
`endif
        for (int i = 0; i < WR_LANES; i++) begin
            wa[i] = '0;
            if (wr_valid[i] && p < DEPTH) begin
                we[i] = 1'b1;
                wa[i] = AW'(p);
                p++;
            end
`ifdef IOARAM_OVF_EN
            else if (wr_valid[i]) drop = 1'b1;
`endif
        end
        cnt_nx = NW'(p);
    end

    // storage write, not reset
    always_ff @(posedge clk) begin
        for (int i = 0; i < WR_LANES; i++) begin
            if (we[i]) begin
                mem_d[wr_ch][wa[i]] <= wr_data[i*DW +: DW];
                mem_i[wr_ch][wa[i]] <= wr_idx[i*IW +: IW];
            end
        end
    end

    // counts: zap (bank leaving input role) overrides everything, clear precedes the write
    always_ff @(posedge clk) begin
        if (rst || zap) begin
            for (int c = 0; c < NUM_CH; c++) cnt[c] <= '0;
        end else begin
            if (clr) for (int c = 0; c < NUM_CH; c++) cnt[c] <= '0;
            if (|wr_valid) cnt[wr_ch] <= cnt_nx;
        end
    end

    // masked multi-lane read of the pre-write state
    always_comb begin
        rd_cnt = cnt[rd_ch];
        rd_lane_valid = '0;
        rd_data = '0;
        rd_idx = '0;
        for (int i = 0; i < RD_LANES; i++) begin
            q = int'(rd_base) + i;
            rd_lane_valid[i] = q < int'(rd_cnt) && q < DEPTH;
            rd_data[i*DW +: DW] = rd_lane_valid[i] ? mem_d[rd_ch][AW'(q)] : '0;
            rd_idx[i*IW +: IW] = rd_lane_valid[i] ? mem_i[rd_ch][AW'(q)] : '0;
        end
    end
endmodule

// File: rtl/sparse_pingpong_aram.sv
// sparse_pingpong_aram: ping-pong activation RAM, fill/writeback routing, registered read (ovf_o with IOARAM_OVF_EN)
module sparse_pingpong_aram
    import sparse_pe_pkg::*;
#(
    parameter int NUM_CH   = ARAM_NUM_CH,
    parameter int DEPTH    = ARAM_DEPTH,
    parameter int DW       = ARAM_DW,
    parameter int IW       = ARAM_IW,
    parameter int WR_LANES = ARAM_WR_LANES,
    parameter int RD_LANES = ARAM_RD_LANES
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [WR_LANES-1:0]          fill_valid_i,
    input  logic [$clog2(NUM_CH)-1:0]    fill_ch_i,
    input  logic [WR_LANES*DW-1:0]       fill_data_i,
    input  logic [WR_LANES*IW-1:0]       fill_idx_i,
    input  logic [WR_LANES-1:0]          wb_valid_i,
    input  logic [$clog2(NUM_CH)-1:0]    wb_ch_i,
    input  logic [WR_LANES*DW-1:0]       wb_data_i,
    input  logic [WR_LANES*IW-1:0]       wb_idx_i,
    input  logic                         clr_i,
    input  logic                         swap_i,
    input  logic                         rd_req_i,
    input  logic [$clog2(NUM_CH)-1:0]    rd_ch_i,
    input  logic [$clog2(DEPTH)-1:0]     rd_base_i,
    output logic                         rd_valid_o,
    output logic [RD_LANES-1:0]          rd_lane_valid_o,
    output logic [RD_LANES*DW-1:0]       rd_data_o,
    output logic [RD_LANES*IW-1:0]       rd_idx_o,
    output logic [$clog2(DEPTH+1)-1:0]   rd_cnt_o,
    output logic                         bank_sel_o
`ifdef IOARAM_OVF_EN
    ,
    output logic                         ovf_o
`endif
);
    logic [RD_LANES-1:0]        lv  [2];
    logic [RD_LANES*DW-1:0]     dat [2];
    logic [RD_LANES*IW-1:0]     idx [2];
    logic [$clog2(DEPTH+1)-1:0] cnt [2];
`ifdef IOARAM_OVF_EN
    logic [1:0] drop;
`endif

    for (genvar b = 0; b < 2; b++) begin : g_bank
        logic in_b;
        assign in_b = bank_sel_o == 1'(b);
        aram_bank #(
            .NUM_CH(NUM_CH), .DEPTH(DEPTH), .DW(DW), .IW(IW),
            .WR_LANES(WR_LANES), .RD_LANES(RD_LANES)
        ) u_bank (
            .clk(clk),
            .rst(rst),
            .clr(in_b && clr_i && !swap_i),
            .zap(in_b && swap_i),
            .wr_valid(in_b ? fill_valid_i : wb_valid_i),
            .wr_ch(in_b ? fill_ch_i : wb_ch_i),
            .wr_data(in_b ? fill_data_i : wb_data_i),
            .wr_idx(in_b ? fill_idx_i : wb_idx_i),
            .rd_ch(rd_ch_i),
            .rd_base(rd_base_i),
            .rd_lane_valid(lv[b]),
            .rd_data(dat[b]),
            .rd_idx(idx[b]),
            .rd_cnt(cnt[b])
`ifdef IOARAM_OVF_EN
            ,
            .drop(drop[b])
`endif
        );
    end

    // input-bank selector, toggled at layer boundaries
    always_ff @(posedge clk) begin
        if (rst) bank_sel_o <= 1'b0;
        else if (swap_i) bank_sel_o <= ~bank_sel_o;
    end

    // one-cycle read response from the current input bank
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid_o <= 1'b0;
            rd_lane_valid_o <= '0;
            rd_data_o <= '0;
            rd_idx_o <= '0;
            rd_cnt_o <= '0;
        end else begin
            rd_valid_o <= rd_req_i;
            rd_lane_valid_o <= rd_req_i ? lv[bank_sel_o] : '0;
            rd_data_o <= rd_req_i ? dat[bank_sel_o] : '0;
            rd_idx_o <= rd_req_i ? idx[bank_sel_o] : '0;
            rd_cnt_o <= rd_req_i ? cnt[bank_sel_o] : '0;
        end
    end

`ifdef IOARAM_OVF_EN
    // sticky overflow on any dropped lane from either port
    always_ff @(posedge clk) begin
        if (rst) ovf_o <= 1'b0;
        else if (|drop) ovf_o <= 1'b1;
    end
`endif
endmodule
